// File: rtl/result_scroll_buffer.sv
// result_scroll_buffer: holds the calculator result matrix and lets the
// user scroll through the stored elements with debounced next/prev buttons.

module result_scroll_debounce #(
    parameter int DB_CYCLES = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic raw,
    output logic press
);
    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] RUN_MAX = CW'(DB_CYCLES);
    localparam logic [CW-1:0] RUN_ONE = CW'(1);

    logic          raw_q;
    logic          level;
    logic [CW-1:0] cnt;
    logic [CW-1:0] run;

    // length of the current stable run including this cycle, saturating
    always_comb begin
        run = cnt;
        if (raw != raw_q) begin
            run = RUN_ONE;
        end else if (cnt != RUN_MAX) begin
            run = cnt + RUN_ONE;
        end
    end

    // adopt the raw level once stable long enough; pulse on a new press
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            raw_q <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            raw_q <= raw;
            cnt   <= run;
            press <= 1'b0;
            if (run == RUN_MAX && raw != level) begin
                level <= raw;
                press <= raw;
            end
        end
    end
endmodule

module result_scroll_buffer #(
    parameter int DATA_W    = 5,
    parameter int IDX_W     = 4,
    parameter int DB_CYCLES = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] res_data,
    input  logic [IDX_W-1:0]  res_index,
    input  logic              res_valid,
    input  logic              res_finish,
    input  logic              res_error,
    input  logic              btn_next,
    input  logic              btn_prev,
    input  logic              clear,
    output logic [DATA_W-1:0] disp_data,
    output logic [IDX_W-1:0]  disp_index,
    output logic              disp_valid,
    output logic [IDX_W:0]    count,
    output logic              err_flag
);
    localparam int DEPTH = 2 ** IDX_W;
    localparam logic [IDX_W-1:0] PTR_ONE = IDX_W'(1);
    localparam logic [IDX_W:0]   CNT_ONE = (IDX_W + 1)'(1);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        BROWSE,
        ERROR
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  ptr_nx;
    logic [IDX_W-1:0]  ptr_inc;
    logic [IDX_W-1:0]  ptr_dec;
    logic [IDX_W:0]    count_nx;
    logic [IDX_W:0]    idx_plus;
    logic [IDX_W:0]    last;
    logic              wr_en;
    logic              next_p;
    logic              prev_p;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] disp_nx;
    logic [DATA_W-1:0] mem [DEPTH];

    result_scroll_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_next (
        .clock   (clock),
        .reset_n (reset_n),
        .raw     (btn_next),
        .press   (next_p)
    );

    result_scroll_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_prev (
        .clock   (clock),
        .reset_n (reset_n),
        .raw     (btn_prev),
        .press   (prev_p)
    );

    // wrap-around pointer steps within the stored element range
    always_comb begin
        idx_plus = {1'b0, res_index} + CNT_ONE;
        last     = count - CNT_ONE;
        ptr_inc  = ({1'b0, ptr} == last) ? '0 : ptr + PTR_ONE;
        ptr_dec  = (ptr == '0) ? last[IDX_W-1:0] : ptr - PTR_ONE;
    end

    // next-state, pointer, count and write-enable decode
    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        count_nx = count;
        wr_en    = 1'b0;
        if (clear) begin
            state_nx = IDLE;
            ptr_nx   = '0;
            count_nx = '0;
        end else if (res_error) begin
            state_nx = ERROR;
            ptr_nx   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (res_valid) begin
                        wr_en    = 1'b1;
                        count_nx = idx_plus;
                        state_nx = CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (res_valid) begin
                        wr_en = 1'b1;
                        if (idx_plus > count) begin
                            count_nx = idx_plus;
                        end
                    end
                    if (res_finish && count_nx != '0) begin
                        state_nx = BROWSE;
                        ptr_nx   = '0;
                    end
                end
                BROWSE: begin
                    if (res_valid) begin
                        wr_en    = 1'b1;
                        count_nx = idx_plus;
                        ptr_nx   = '0;
                        state_nx = CAPTURE;
                    end else if (next_p && !prev_p) begin
                        ptr_nx = ptr_inc;
                    end else if (prev_p && !next_p) begin
                        ptr_nx = ptr_dec;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // display word lags the pointer by one cycle; forward a same-cycle write
    always_comb begin
        rd_data = mem[ptr];
        if (wr_en && res_index == ptr) begin
            rd_data = res_data;
        end
        disp_nx = (state_nx == BROWSE) ? rd_data : '0;
    end

    // result element storage, contents undefined after reset
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[res_index] <= res_data;
        end
    end

    // state, pointer, count and display registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            ptr       <= '0;
            count     <= '0;
            disp_data <= '0;
        end else begin
            state     <= state_nx;
            ptr       <= ptr_nx;
            count     <= count_nx;
            disp_data <= disp_nx;
        end
    end

    assign disp_index = ptr;
    assign disp_valid = (state == BROWSE);
    assign err_flag   = (state == ERROR);
endmodule

// File: tb/tb_result_scroll_buffer.sv
// tb_result_scroll_buffer: directed scenarios plus random traffic, all
// checked each cycle against a behavioural model of the scroll buffer.

module tb_result_scroll_buffer;
    localparam int DB = 16;
    localparam int S_IDLE = 0;
    localparam int S_CAP = 1;
    localparam int S_BRW = 2;
    localparam int S_ERR = 3;

    logic       clock;
    logic       reset_n;
    logic [4:0] res_data;
    logic [3:0] res_index;
    logic       res_valid;
    logic       res_finish;
    logic       res_error;
    logic       btn_next;
    logic       btn_prev;
    logic       clear;
    logic [4:0] disp_data;
    logic [3:0] disp_index;
    logic       disp_valid;
    logic [4:0] count;
    logic       err_flag;

    int total = 0;
    int bad = 0;
    bit started = 0;

    // model state
    int m_mem[16];
    int m_state, m_cnt, m_ptr, m_dd, m_prev;
    int m_run[2];
    bit m_last[2], m_db[2], m_pulse[2], m_np[2], m_raw[2];

    result_scroll_buffer dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .res_data   (res_data),
        .res_index  (res_index),
        .res_valid  (res_valid),
        .res_finish (res_finish),
        .res_error  (res_error),
        .btn_next   (btn_next),
        .btn_prev   (btn_prev),
        .clear      (clear),
        .disp_data  (disp_data),
        .disp_index (disp_index),
        .disp_valid (disp_valid),
        .count      (count),
        .err_flag   (err_flag)
    );

    initial clock = 0;
    always #5 clock = ~clock;

    initial begin
        for (int i = 0; i < 16; i++) m_mem[i] = -1;
    end

    // behavioural model: one step per rising edge
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_state = S_IDLE;
            m_cnt = 0;
            m_ptr = 0;
            m_dd = 0;
            for (int b = 0; b < 2; b++) begin
                m_run[b] = 0;
                m_last[b] = 0;
                m_db[b] = 0;
                m_pulse[b] = 0;
            end
        end else begin
            m_prev = m_ptr;
            if (clear) begin
                m_state = S_IDLE;
                m_cnt = 0;
                m_ptr = 0;
            end else if (res_error) begin
                m_state = S_ERR;
                m_ptr = 0;
            end else if (m_state == S_IDLE) begin
                if (res_valid) begin
                    m_mem[res_index] = res_data;
                    m_cnt = res_index + 1;
                    m_state = S_CAP;
                end
            end else if (m_state == S_CAP) begin
                if (res_valid) begin
                    m_mem[res_index] = res_data;
                    if (res_index + 1 > m_cnt) m_cnt = res_index + 1;
                end
                if (res_finish && m_cnt > 0) begin
                    m_state = S_BRW;
                    m_ptr = 0;
                end
            end else if (m_state == S_BRW) begin
                if (res_valid) begin
                    m_mem[res_index] = res_data;
                    m_cnt = res_index + 1;
                    m_ptr = 0;
                    m_state = S_CAP;
                end else if (m_pulse[0] && !m_pulse[1]) begin
                    m_ptr = (m_ptr + 1) % m_cnt;
                end else if (m_pulse[1] && !m_pulse[0]) begin
                    m_ptr = (m_ptr + m_cnt - 1) % m_cnt;
                end
            end
            m_raw[0] = btn_next;
            m_raw[1] = btn_prev;
            for (int b = 0; b < 2; b++) begin
                if (m_raw[b] != m_last[b]) m_run[b] = 1;
                else if (m_run[b] < DB) m_run[b]++;
                m_last[b] = m_raw[b];
                m_np[b] = 0;
                if (m_run[b] >= DB && m_db[b] != m_raw[b]) begin
                    m_db[b] = m_raw[b];
                    m_np[b] = m_raw[b];
                end
                m_pulse[b] = m_np[b];
            end
            m_dd = (m_state == S_BRW) ? m_mem[m_prev] : 0;
        end
    end

    // per-cycle comparison of every output against the model
    always @(negedge clock) begin
        if (started) begin
            total++;
            if (disp_index !== 4'(m_ptr)
                || disp_valid !== (m_state == S_BRW)
                || count !== 5'(m_cnt)
                || err_flag !== (m_state == S_ERR)
                || (m_dd >= 0 && disp_data !== 5'(m_dd))) begin
                bad++;
                $display("FAIL outputs t=%0t got idx=%0d dat=%0d vld=%0b cnt=%0d err=%0b want idx=%0d dat=%0d vld=%0b cnt=%0d err=%0b",
                         $time, disp_index, disp_data, disp_valid, count, err_flag,
                         m_ptr, m_dd, m_state == S_BRW, m_cnt, m_state == S_ERR);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic put(input int idx, input int val);
        res_valid = 1;
        res_index = 4'(idx);
        res_data = 5'(val);
        step();
        res_valid = 0;
    endtask

    task automatic press(input bit nxt, input bit prv, input int hold);
        btn_next = nxt;
        btn_prev = prv;
        step(hold);
        btn_next = 0;
        btn_prev = 0;
        step(DB + 4);
    endtask

    initial begin
        reset_n = 0;
        res_data = 0;
        res_index = 0;
        res_valid = 0;
        res_finish = 0;
        res_error = 0;
        btn_next = 0;
        btn_prev = 0;
        clear = 0;
        step(3);
        reset_n = 1;
        started = 1;
        step();
        chk("reset_valid", disp_valid, 0);
        chk("reset_count", count, 0);
        chk("reset_err", err_flag, 0);

        // nine elements, then finish
        for (int i = 0; i < 9; i++) put(i, (3 * i) % 32);
        res_finish = 1;
        step();
        res_finish = 0;
        step();
        chk("fill9_count", count, 9);
        chk("fill9_model_count", m_cnt, 9);
        chk("fill9_idx", disp_index, 0);
        chk("fill9_data", disp_data, 0);
        chk("fill9_valid", disp_valid, 1);

        // nine next presses wrap back to 0, then prev from 0 goes to 8
        for (int k = 1; k <= 9; k++) begin
            press(1, 0, DB + 4);
            chk("next_idx", disp_index, k % 9);
            chk("next_data", disp_data, 3 * (k % 9));
        end
        press(0, 1, DB + 4);
        chk("prev_wrap_idx", disp_index, 8);
        chk("prev_wrap_data", disp_data, 24);

        // bouncing input never settles long enough
        for (int t = 0; t < 8; t++) begin
            btn_next = ~btn_next;
            step(5);
        end
        btn_next = 0;
        step(DB + 4);
        chk("bounce_idx", disp_index, 8);

        // a long hold is a single step
        press(1, 0, 100);
        chk("hold_idx", disp_index, 0);
        chk("hold_model_idx", m_ptr, 0);

        // simultaneous presses cancel
        press(1, 1, DB + 4);
        chk("both_idx", disp_index, 0);

        // reset while browsing
        reset_n = 0;
        step();
        reset_n = 1;
        chk("midreset_valid", disp_valid, 0);
        chk("midreset_count", count, 0);
        chk("midreset_data", disp_data, 0);

        // full sixteen-element matrix
        for (int i = 0; i < 16; i++) put(i, (7 * i + 1) % 32);
        res_finish = 1;
        step();
        res_finish = 0;
        step();
        chk("fill16_count", count, 16);
        press(0, 1, DB + 4);
        chk("fill16_prev_idx", disp_index, 15);
        chk("fill16_prev_data", disp_data, 10);
        press(1, 0, DB + 4);
        chk("fill16_next_idx", disp_index, 0);
        chk("fill16_next_data", disp_data, 1);

        // error during capture, buttons ignored, clear recovers
        put(2, 9);
        res_error = 1;
        step();
        res_error = 0;
        chk("err_flag", err_flag, 1);
        chk("err_valid", disp_valid, 0);
        chk("err_data", disp_data, 0);
        press(1, 0, DB + 4);
        chk("err_hold", err_flag, 1);
        chk("err_idx", disp_index, 0);
        clear = 1;
        step();
        clear = 0;
        chk("clear_err", err_flag, 0);
        chk("clear_count", count, 0);

        // random traffic
        for (int c = 0; c < 6000; c++) begin
            res_valid = ($urandom_range(0, 9) == 0);
            res_index = 4'($urandom_range(0, 15));
            res_data = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 39) == 0) res_finish = ~res_finish;
            res_error = ($urandom_range(0, 699) == 0);
            clear = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 29) == 0) btn_next = ~btn_next;
            if ($urandom_range(0, 29) == 0) btn_prev = ~btn_prev;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
